// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared types for the reorder buffer: per-entry state, instruction kind and
// the "no destination register" encoding. Imported by every ROB file.
// ---------------------------------------------------------------------------
package rob_pkg;

  typedef enum logic [2:0] {
    EMPTY     = 3'd0,
    EXEC      = 3'd1,
    LS_READY  = 3'd2,
    LS_ISSUED = 3'd3,
    DONE      = 3'd4
  } rob_state_e;

  typedef enum logic [1:0] {
    ALU    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    MEM    = 2'd3
  } rob_kind_e;

  localparam logic [4:0] NO_RD = 5'd0;

  // An entry only takes a result while it is still waiting for one.
  function automatic logic wb_accepts(input rob_state_e s);
    return (s == EXEC) || (s == LS_ISSUED);
  endfunction

endpackage

// File: rtl/rob_param_if.sv
// ---------------------------------------------------------------------------
// rob_param_if
// Bundles every ROB-facing signal except clk/rst.
//   master : the core side (decode, execution units, LSB, fetch)
//   slave  : the reorder buffer itself
// Signal groups: alloc_* (decode -> ROB), wb_* (writeback ports, packed per
// port), ls_ready_* (LSB address-ready), commit_* / ls_commit* / redirect_*
// (ROB -> regfile, LSB, fetch), count (occupancy).
// Optional: ROB_FWD_EN adds two operand lookup ports q_tag/q_ready/q_value.
// ---------------------------------------------------------------------------
interface rob_param_if #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
);
  import rob_pkg::*;

  localparam int TAG_W = $clog2(DEPTH);

  logic                    alloc_valid;
  rob_kind_e               alloc_kind;
  logic [4:0]              alloc_rd;
  logic [XLEN-1:0]         alloc_pc;
  logic [XLEN-1:0]         alloc_imm;
  logic                    alloc_ready;
  logic [TAG_W-1:0]        alloc_tag;

  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]  wb_value;

  logic                    ls_ready_valid;
  logic [TAG_W-1:0]        ls_ready_tag;

  logic                    commit_valid;
  logic [TAG_W-1:0]        commit_tag;
  logic [4:0]              commit_rd;
  logic [XLEN-1:0]         commit_value;
  logic                    ls_commit;
  logic [TAG_W-1:0]        ls_commit_tag;
  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic [TAG_W:0]          count;

`ifdef ROB_FWD_EN
  logic [TAG_W-1:0]        q_tag   [2];
  logic                    q_ready [2];
  logic [XLEN-1:0]         q_value [2];
`endif

  modport master (
`ifdef ROB_FWD_EN
    output q_tag, input q_ready, input q_value,
`endif
    output alloc_valid, alloc_kind, alloc_rd, alloc_pc, alloc_imm,
    input  alloc_ready, alloc_tag,
    output wb_valid, wb_tag, wb_value,
    output ls_ready_valid, ls_ready_tag,
    input  commit_valid, commit_tag, commit_rd, commit_value,
    input  ls_commit, ls_commit_tag, redirect_valid, redirect_pc, count
  );

  modport slave (
`ifdef ROB_FWD_EN
    input q_tag, output q_ready, output q_value,
`endif
    input  alloc_valid, alloc_kind, alloc_rd, alloc_pc, alloc_imm,
    output alloc_ready, alloc_tag,
    input  wb_valid, wb_tag, wb_value,
    input  ls_ready_valid, ls_ready_tag,
    output commit_valid, commit_tag, commit_rd, commit_value,
    output ls_commit, ls_commit_tag, redirect_valid, redirect_pc, count
  );

endinterface

// File: rtl/rob_entry_fsm.sv
// ---------------------------------------------------------------------------
// rob_entry_fsm
// Lifecycle of one ROB entry: EMPTY -> EXEC -> (LS_READY -> LS_ISSUED) ->
// DONE -> EMPTY. Flush has priority over every other event.
// Ports:
//   clk, rst      clock, async active-high reset (-> EMPTY)
//   i_alloc       this entry is the tail and is being allocated
//   i_alloc_done  allocation carries a pre-computed result (goes to DONE)
//   i_wb          a writeback port targets this entry
//   i_ls_ready    LSB marks this MEM entry address-ready
//   i_ls_issue    head is releasing this entry to the LSB
//   i_commit      head is retiring this entry
//   i_flush       redirect: discard everything
//   o_state       current state
// ---------------------------------------------------------------------------
module rob_entry_fsm
  import rob_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alloc,
  input  logic       i_alloc_done,
  input  logic       i_wb,
  input  logic       i_ls_ready,
  input  logic       i_ls_issue,
  input  logic       i_commit,
  input  logic       i_flush,
  output rob_state_e o_state
);

  rob_state_e r_state;
  rob_state_e w_state_nxt;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value; the combinational block below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the hold value is assigned first so no path leaves w_state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY:     if (i_alloc) w_state_nxt = i_alloc_done ? DONE : EXEC;
        EXEC: begin
          if (i_wb)            w_state_nxt = DONE;
          else if (i_ls_ready) w_state_nxt = LS_READY;
        end
        LS_READY:  if (i_ls_issue) w_state_nxt = LS_ISSUED;
        LS_ISSUED: if (i_wb)       w_state_nxt = DONE;
        DONE:      if (i_commit)   w_state_nxt = EMPTY;
        default:   w_state_nxt = EMPTY;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/rob_param.sv
// ---------------------------------------------------------------------------
// rob_param
// In-order-retire reorder buffer, DEPTH entries, NUM_WB writeback ports,
// one head action per cycle (commit or LSB release). A committed taken
// BRANCH or any JUMP flushes every entry and redirects fetch.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  rob_param_if.slave: alloc, writeback, ls_ready, commit, ls_commit,
//        redirect, count (and q_* lookup ports when ROB_FWD_EN is defined)
// Configuration macro: ROB_FWD_EN enables combinational operand forwarding.
// An ALU allocation with rd != 0 and a non-zero alloc_imm is treated as a
// pre-decoded LUI/AUIPC: its imm is the result and it is born DONE.
// ---------------------------------------------------------------------------
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
) (
  input  logic       clk,
  input  logic       rst,
  rob_param_if.slave bus
);

  localparam int TAG_W = $clog2(DEPTH);
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;

  // Pointers, occupancy and registered outputs
  tag_t            r_head, r_tail;
  cnt_t            r_count;
  logic            r_commit_valid, r_ls_commit, r_redirect_valid;
  tag_t            r_commit_tag, r_ls_commit_tag;
  logic [4:0]      r_commit_rd;
  logic [XLEN-1:0] r_commit_value, r_redirect_pc;

  // Entry payload
  rob_kind_e       r_kind  [DEPTH];
  logic [4:0]      r_rd    [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_imm   [DEPTH];
  logic [XLEN-1:0] r_value [DEPTH];
  rob_state_e      w_state [DEPTH];

  // Per-entry event decode
  logic [DEPTH-1:0] w_alloc_sel, w_wb_hit, w_ls_hit;
  logic [XLEN-1:0]  w_wb_val [DEPTH];

  logic            w_alloc_ready, w_alloc, w_preset;
  logic            w_commit, w_ls_issue, w_redirect;
  rob_kind_e       w_head_kind;
  logic [XLEN-1:0] w_commit_value, w_redirect_pc;

  assign w_alloc_ready = r_count < cnt_t'(DEPTH);
  assign w_alloc       = bus.alloc_valid && w_alloc_ready;
  assign w_preset      = (bus.alloc_kind == ALU) && (bus.alloc_rd != NO_RD) &&
                         (bus.alloc_imm != '0);

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_alloc_sel[e] = w_alloc && (r_tail == tag_t'(e));
      w_wb_hit[e]    = 1'b0;
      w_wb_val[e]    = '0;
      // Ascending scan: a higher-index port on the same tag overrides.
      for (int k = 0; k < NUM_WB; k++) begin
        if (bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == tag_t'(e))) begin
          w_wb_hit[e] = 1'b1;
          w_wb_val[e] = bus.wb_value[k*XLEN +: XLEN];
        end
      end
      w_ls_hit[e] = bus.ls_ready_valid && (bus.ls_ready_tag == tag_t'(e)) &&
                    (r_kind[e] == MEM);
    end
  end

  // Head selection: exactly one of commit / LSB release / nothing.
  always_comb begin
    w_head_kind    = r_kind[r_head];
    w_commit       = (w_state[r_head] == DONE);
    w_ls_issue     = (w_state[r_head] == LS_READY);
    w_redirect     = w_commit && ((w_head_kind == JUMP) ||
                                  ((w_head_kind == BRANCH) && r_value[r_head][0]));
    w_commit_value = (w_head_kind == JUMP) ? r_pc[r_head] + XLEN'(4) : r_value[r_head];
    w_redirect_pc  = (w_head_kind == JUMP) ? r_value[r_head] : r_imm[r_head];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rob_entry_fsm u_fsm (
      .clk          (clk),
      .rst          (rst),
      .i_alloc      (w_alloc_sel[g]),
      .i_alloc_done (w_preset),
      .i_wb         (w_wb_hit[g]),
      .i_ls_ready   (w_ls_hit[g]),
      .i_ls_issue   (w_ls_issue && (r_head == tag_t'(g))),
      .i_commit     (w_commit && (r_head == tag_t'(g))),
      .i_flush      (w_redirect),
      .o_state      (w_state[g])
    );
  end

  // NOTE: the payload arrays have no reset: an entry is only read while its
  // FSM is non-EMPTY, and allocation always writes it first.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (!w_redirect) begin
        if (w_alloc_sel[e]) begin
          r_kind[e]  <= bus.alloc_kind;
          r_rd[e]    <= bus.alloc_rd;
          r_pc[e]    <= bus.alloc_pc;
          r_imm[e]   <= bus.alloc_imm;
          r_value[e] <= w_preset ? bus.alloc_imm : '0;
        end else if (w_wb_hit[e] && wb_accepts(w_state[e])) begin
          r_value[e] <= w_wb_val[e];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_commit_valid   <= 1'b0;
      r_commit_tag     <= '0;
      r_commit_rd      <= '0;
      r_commit_value   <= '0;
      r_ls_commit      <= 1'b0;
      r_ls_commit_tag  <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_commit_valid   <= w_commit;
      r_ls_commit      <= w_ls_issue;
      r_redirect_valid <= w_redirect;
      if (w_commit) begin
        r_commit_tag   <= r_head;
        r_commit_rd    <= r_rd[r_head];
        r_commit_value <= w_commit_value;
      end
      if (w_ls_issue) r_ls_commit_tag <= r_head;
      if (w_redirect) r_redirect_pc   <= w_redirect_pc;

      if (w_redirect) begin
        // Everything younger is gone; restart allocation just past the
        // retiring branch/jump.
        r_head  <= r_head + tag_t'(1);
        r_tail  <= r_head + tag_t'(1);
        r_count <= '0;
      end else begin
        if (w_commit) r_head <= r_head + tag_t'(1);
        if (w_alloc)  r_tail <= r_tail + tag_t'(1);
        unique case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + cnt_t'(1);
          2'b01:   r_count <= r_count - cnt_t'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.alloc_ready    = w_alloc_ready;
  assign bus.alloc_tag      = r_tail;
  assign bus.commit_valid   = r_commit_valid;
  assign bus.commit_tag     = r_commit_tag;
  assign bus.commit_rd      = r_commit_rd;
  assign bus.commit_value   = r_commit_value;
  assign bus.ls_commit      = r_ls_commit;
  assign bus.ls_commit_tag  = r_ls_commit_tag;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.count          = r_count;

`ifdef ROB_FWD_EN
  // Operand lookup: a result is visible either from the entry (DONE) or
  // straight off a writeback port in the same cycle.
  logic w_q_hit [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus.q_ready[i] = 1'b0;
      bus.q_value[i] = '0;
      w_q_hit[i]     = w_wb_hit[bus.q_tag[i]] && wb_accepts(w_state[bus.q_tag[i]]);
      if ((w_state[bus.q_tag[i]] == DONE) || w_q_hit[i]) begin
        bus.q_ready[i] = 1'b1;
        if (r_kind[bus.q_tag[i]] == JUMP)
          bus.q_value[i] = r_pc[bus.q_tag[i]] + XLEN'(4);
        else if (w_q_hit[i])
          bus.q_value[i] = w_wb_val[bus.q_tag[i]];
        else
          bus.q_value[i] = r_value[bus.q_tag[i]];
      end
    end
  end
`endif

endmodule
